// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit                                                    |
// | Purpose  : Instruction fetch front end. Owns the fetch PC, issues        |
// |            in-order 32-bit reads to instruction memory, queues returned  |
// |            words with their PCs, and hands them to decode over           |
// |            valid/ready. A redirect flushes the queue, drops responses    |
// |            still in flight, and restarts at the new address.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   RESET_PC       first fetch address after reset                         |
// |   FIFO_DEPTH     queue entries; also caps queued+in-flight+discard (>=2)  |
// | Ports                                                                    |
// |   clk_i, rst_ni            clock (rising edge), async active-low reset    |
// |   imem_req_o/addr_o        read request and its byte address             |
// |   imem_gnt_i               request accepted this cycle                   |
// |   imem_rvalid_i/rdata_i    in-order read response                        |
// |   instr_valid_o/ready_i    handshake towards decode                      |
// |   instr_o/instr_pc_o       head instruction word and its PC              |
// |   redirect_i/redirect_pc_i flush and restart                             |
// | Configuration macro                                                      |
// |   FETCH_BYPASS_EN  when defined, a response arriving while the queue is  |
// |                    empty and decode is ready is forwarded in the same    |
// |                    cycle instead of being queued.                        |
// +--------------------------------------------------------------------------+
module fetch_unit #(
   parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        imem_req_o,
   output logic [63:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [63:0] instr_pc_o,
   input  logic        redirect_i,
   input  logic [63:0] redirect_pc_i
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned SW = CW + 2;
   localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);
   localparam logic [SW-1:0] DEPTH_S  = SW'(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

   logic [63:0]   fetch_pc_q, fetch_pc_d;
   logic [63:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   mem_instr_q [FIFO_DEPTH];
   logic [63:0]   mem_pc_q    [FIFO_DEPTH];

   logic [63:0]   redirect_aligned;
   logic [SW-1:0] credit_used;
   logic          empty;
   logic          fire;
   logic          resp_keep;
   logic          bypass;
   logic          push;
   logic          pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + 1'b1;
   endfunction

   assign redirect_aligned = redirect_pc_i & ~64'h3;

   // Queued words, words in flight and words owed to discard all hold a
   // queue slot, so a response can always be pushed.
   assign credit_used = SW'(count_q) + SW'(inflight_q) + SW'(discard_q);
   assign empty       = (count_q == '0);

   always_comb begin
      imem_req_o  = rst_ni && !redirect_i && (credit_used < DEPTH_S);
      imem_addr_o = fetch_pc_q;
      fire        = imem_req_o && imem_gnt_i;
      // Responses owed to an earlier redirect are consumed first.
      resp_keep   = imem_rvalid_i && !redirect_i && (discard_q == '0);
`ifdef FETCH_BYPASS_EN
      bypass      = resp_keep && empty && instr_ready_i;
`else
      bypass      = 1'b0;
`endif
      push        = resp_keep && !bypass;
      pop         = !empty && instr_ready_i && !redirect_i;

      instr_valid_o = !empty || bypass;
      instr_o       = '0;
      instr_pc_o    = '0;
      if (bypass) begin
         instr_o    = imem_rdata_i;
         instr_pc_o = resp_pc_q;
      end else if (!empty) begin
         instr_o    = mem_instr_q[rd_ptr_q];
         instr_pc_o = mem_pc_q[rd_ptr_q];
      end
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      discard_d  = discard_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      if (redirect_i) begin
         fetch_pc_d = redirect_aligned;
         resp_pc_d  = redirect_aligned;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         inflight_d = '0;
         // Everything still owed by memory becomes discard; a response
         // landing in this very cycle settles one of those debts.
         discard_d  = discard_q + inflight_q - CW'(imem_rvalid_i);
      end else begin
         if (fire) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
         end
         if (imem_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
         end
         inflight_d = inflight_q + CW'(fire) - CW'(resp_keep);
         if (resp_keep) begin
            resp_pc_d = resp_pc_q + 64'd4;
         end
         if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         count_q    <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_instr_q[i] <= '0;
            mem_pc_q[i]    <= '0;
         end
      end else if (push) begin
         mem_instr_q[wr_ptr_q] <= imem_rdata_i;
         mem_pc_q[wr_ptr_q]    <= resp_pc_q;
      end
   end

   a_no_orphan_rvalid : assert property (@(posedge clk_i) disable iff (!rst_ni)
      imem_rvalid_i |-> ((inflight_q != '0) || (discard_q != '0)));

   a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (push && !pop) |-> (count_q != DEPTH_C));

endmodule
`default_nettype wire
